// File: rtl/cdc_clear_seq_ctrl.sv
// Clear-sequence controller for one side of a CDC clear handshake.
// Walks IDLE -> ISOLATE -> CLEAR -> POST_CLEAR -> IDLE, drives the local
// isolate/clear controls, and publishes every phase entry over a
// valid/ready handshake to the phase-transport stage. A phase is never left
// before its publication has been accepted downstream.

package cdc_clear_sync_pkg;
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISOLATE    = 2'd1,
      CLEAR      = 2'd2,
      POST_CLEAR = 2'd3
   } clear_seq_phase_e;
endpackage

module cdc_clear_seq_ctrl #(
   parameter int CLEAR_CYCLES      = 3,
   parameter int POST_CLEAR_CYCLES = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 clear_req_i,
   output logic                                 isolate_o,
   input  logic                                 isolate_ack_i,
   output logic                                 clear_o,
   output cdc_clear_sync_pkg::clear_seq_phase_e phase_o,
   output logic                                 phase_valid_o,
   input  logic                                 phase_ready_i,
   output logic                                 busy_o,
   output logic                                 clear_done_o
);

   import cdc_clear_sync_pkg::*;

   // Counter is shared by CLEAR and POST_CLEAR, so it is sized for the longer one.
   localparam int MAX_CYCLES = (CLEAR_CYCLES > POST_CLEAR_CYCLES) ? CLEAR_CYCLES
                                                                  : POST_CLEAR_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POST_CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   clear_seq_phase_e state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             pending_reg, pending_next;
   logic             valid_reg, valid_next;
   logic             isolate_reg, isolate_next;
   logic             clear_reg, clear_next;
   logic             done_reg, done_next;
   logic             busy_reg, busy_next;

   // Current phase publication is complete: nothing outstanding, or it is
   // being accepted on this very edge.
   logic hs_done;
   logic state_change;
   logic go_isolate;

   assign hs_done      = !valid_reg || phase_ready_i;
   assign state_change = (state_next != state_reg);
   assign go_isolate   = (state_reg == IDLE) && (state_next == ISOLATE);

   // State and registered outputs; reset drops any in-flight sequence silently.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         pending_reg <= 1'b0;
         valid_reg   <= 1'b0;
         isolate_reg <= 1'b0;
         clear_reg   <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pending_reg <= pending_next;
         valid_reg   <= valid_next;
         isolate_reg <= isolate_next;
         clear_reg   <= clear_next;
         done_reg    <= done_next;
         busy_reg    <= busy_next;
      end
   end

   // Next-state logic: every advance also waits for the current phase's publication.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if ((clear_req_i || pending_reg) && hs_done)
               state_next = ISOLATE;
         end
         ISOLATE: begin
            if (isolate_ack_i && hs_done)
               state_next = CLEAR;
         end
         CLEAR: begin
            if ((cnt_reg == CLEAR_LAST) && hs_done)
               state_next = POST_CLEAR;
         end
         POST_CLEAR: begin
            if ((cnt_reg == POST_LAST) && hs_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output/datapath next values derived from the upcoming state.
   always_comb begin
      cnt_next     = cnt_reg;
      pending_next = pending_reg;
      valid_next   = valid_reg;

      // Dwell counter restarts on every state entry and saturates at the
      // terminal value so a handshake stall cannot wrap it.
      if (state_change) begin
         cnt_next = '0;
      end else if (state_reg == CLEAR) begin
         if (cnt_reg != CLEAR_LAST)
            cnt_next = cnt_reg + CNT_ONE;
      end else if (state_reg == POST_CLEAR) begin
         if (cnt_reg != POST_LAST)
            cnt_next = cnt_reg + CNT_ONE;
      end else begin
         cnt_next = '0;
      end

      // A new state always republishes; otherwise acceptance retires valid.
      if (state_change)
         valid_next = 1'b1;
      else if (valid_reg && phase_ready_i)
         valid_next = 1'b0;

      // Requests arriving while busy collapse into a single pending flag;
      // the IDLE->ISOLATE transition consumes both the flag and a live request.
      if (go_isolate)
         pending_next = 1'b0;
      else if (clear_req_i && busy_reg)
         pending_next = 1'b1;

      isolate_next = (state_next != IDLE);
      clear_next   = (state_next == CLEAR);
      done_next    = (state_reg == POST_CLEAR) && (state_next == IDLE);
      busy_next    = (state_next != IDLE) || valid_next;
   end

   assign phase_o       = state_reg;
   assign phase_valid_o = valid_reg;
   assign isolate_o     = isolate_reg;
   assign clear_o       = clear_reg;
   assign clear_done_o  = done_reg;
   assign busy_o        = busy_reg;

endmodule

// File: tb/tb_cdc_clear_seq_ctrl.sv
// Directed bench for cdc_clear_seq_ctrl. Two instances share the stimulus:
// u_dut0 with default timing, u_dut1 with CLEAR_CYCLES=1 for the stretched
// CLEAR scenario. Cycle cN is the cycle following the Nth edge after the
// stimulus start; inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_cdc_clear_seq_ctrl;
   import cdc_clear_sync_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic clear_req;
   logic isolate_ack;
   logic phase_ready;

   logic d0_isolate, d0_clear, d0_valid, d0_busy, d0_done;
   logic d1_isolate, d1_clear, d1_valid, d1_busy, d1_done;
   clear_seq_phase_e d0_phase, d1_phase;

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   cdc_clear_seq_ctrl #(.CLEAR_CYCLES(3), .POST_CLEAR_CYCLES(2)) u_dut0 (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_req_i  (clear_req),
      .isolate_o    (d0_isolate),
      .isolate_ack_i(isolate_ack),
      .clear_o      (d0_clear),
      .phase_o      (d0_phase),
      .phase_valid_o(d0_valid),
      .phase_ready_i(phase_ready),
      .busy_o       (d0_busy),
      .clear_done_o (d0_done)
   );

   cdc_clear_seq_ctrl #(.CLEAR_CYCLES(1), .POST_CLEAR_CYCLES(2)) u_dut1 (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_req_i  (clear_req),
      .isolate_o    (d1_isolate),
      .isolate_ack_i(isolate_ack),
      .clear_o      (d1_clear),
      .phase_o      (d1_phase),
      .phase_valid_o(d1_valid),
      .phase_ready_i(phase_ready),
      .busy_o       (d1_busy),
      .clear_done_o (d1_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in c0 with all requests low and the DUTs at reset values.
   task automatic do_reset();
      rst       = 1'b1;
      clear_req = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Expected tables for the basic sequence, c1..c7.
   logic [1:0] basic_phase [1:7];
   logic       basic_clear [1:7];
   logic       basic_iso   [1:7];
   logic       basic_valid [1:7];
   logic       basic_done  [1:7];

   initial begin
      int clr_high;
      rst         = 1'b1;
      clear_req   = 1'b0;
      isolate_ack = 1'b1;
      phase_ready = 1'b1;

      basic_phase = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      basic_clear = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      basic_iso   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      basic_valid = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      basic_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // ---------------- reset state ----------------
      step();
      do_reset();
      chk("reset phase",   d0_phase,   IDLE);
      chk("reset valid",   d0_valid,   1'b0);
      chk("reset isolate", d0_isolate, 1'b0);
      chk("reset clear",   d0_clear,   1'b0);
      chk("reset busy",    d0_busy,    1'b0);
      chk("reset done",    d0_done,    1'b0);
      $display("step reset: outputs idle");

      // ---------------- basic sequence ----------------
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("basic c%0d phase", c),   d0_phase,   basic_phase[c]);
         chk($sformatf("basic c%0d clear", c),   d0_clear,   basic_clear[c]);
         chk($sformatf("basic c%0d isolate", c), d0_isolate, basic_iso[c]);
         chk($sformatf("basic c%0d valid", c),   d0_valid,   basic_valid[c]);
         chk($sformatf("basic c%0d done", c),    d0_done,    basic_done[c]);
         step();
      end
      chk("basic c8 valid", d0_valid, 1'b0);
      chk("basic c8 busy",  d0_busy,  1'b0);
      chk("basic c8 done",  d0_done,  1'b0);
      $display("step basic: one sequence IDLE->ISOLATE->CLEAR->POST_CLEAR->IDLE");

      // ---------------- backpressure ----------------
      do_reset();
      phase_ready = 1'b0;
      clear_req   = 1'b1;
      step();
      clear_req = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         chk($sformatf("bp c%0d phase", c), d0_phase, ISOLATE);
         chk($sformatf("bp c%0d valid", c), d0_valid, 1'b1);
         if (c == 9) begin
            step();
            phase_ready = 1'b1;
         end else if (c != 10) begin
            step();
         end
      end
      step();
      chk("bp c11 phase", d0_phase, CLEAR);
      chk("bp c11 valid", d0_valid, 1'b1);
      $display("step backpressure: ISOLATE held until publication accepted");

      // ---------------- isolation delay ----------------
      do_reset();
      isolate_ack = 1'b0;
      clear_req   = 1'b1;
      step();
      clear_req = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("iso c%0d phase", c), d0_phase, ISOLATE);
         chk($sformatf("iso c%0d clear", c), d0_clear, 1'b0);
         if (c == 5) begin
            step();
            isolate_ack = 1'b1;
         end else if (c != 6) begin
            step();
         end
      end
      for (int c = 7; c <= 10; c++) begin
         step();
         chk($sformatf("iso c%0d clear", c), d0_clear, (c <= 9) ? 1'b1 : 1'b0);
         chk($sformatf("iso c%0d phase", c), d0_phase, (c <= 9) ? CLEAR : POST_CLEAR);
      end
      $display("step isolation delay: CLEAR waits for isolate_ack");

      // ---------------- collapsed pending requests ----------------
      do_reset();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         chk($sformatf("pend c%0d done", c), d0_done, (c == 7 || c == 14) ? 1'b1 : 1'b0);
         if (c == 7)  chk("pend c7 phase",  d0_phase, IDLE);
         if (c == 7)  chk("pend c7 valid",  d0_valid, 1'b1);
         if (c == 8)  chk("pend c8 phase",  d0_phase, ISOLATE);
         if (c == 14) chk("pend c14 phase", d0_phase, IDLE);
         if (c == 15) chk("pend c15 busy",  d0_busy,  1'b0);
         clear_req = (c == 3 || c == 4);
         if (c != 15) step();
      end
      step();
      chk("pend c16 phase", d0_phase, IDLE);
      chk("pend c16 done",  d0_done,  1'b0);
      $display("step pending: three requests produce two sequences");

      // ---------------- reset mid-sequence ----------------
      do_reset();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      step();
      step();
      chk("rstmid c3 phase", d0_phase, CLEAR);
      rst       = 1'b1;
      clear_req = 1'b1;
      step();
      rst       = 1'b0;
      clear_req = 1'b0;
      chk("rstmid c4 phase",   d0_phase,   IDLE);
      chk("rstmid c4 clear",   d0_clear,   1'b0);
      chk("rstmid c4 isolate", d0_isolate, 1'b0);
      chk("rstmid c4 valid",   d0_valid,   1'b0);
      chk("rstmid c4 busy",    d0_busy,    1'b0);
      for (int c = 5; c <= 8; c++) begin
         step();
         chk($sformatf("rstmid c%0d done", c),  d0_done,  1'b0);
         chk($sformatf("rstmid c%0d phase", c), d0_phase, IDLE);
      end
      $display("step reset mid-sequence: sequence abandoned without done pulse");

      // ---------------- stretched CLEAR (CLEAR_CYCLES=1) ----------------
      do_reset();
      phase_ready = 1'b1;
      isolate_ack = 1'b1;
      clr_high    = 0;
      clear_req   = 1'b1;
      step();
      clear_req = 1'b0;
      chk("stretch c1 phase", d1_phase, ISOLATE);
      for (int c = 2; c <= 10; c++) begin
         step();
         phase_ready = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
         if (d1_clear) clr_high++;
         if (c == 2) chk("stretch c2 phase", d1_phase, CLEAR);
         if (c == 6) chk("stretch c6 phase", d1_phase, CLEAR);
         if (c == 7) chk("stretch c7 phase", d1_phase, POST_CLEAR);
         if (c == 7) chk("stretch c7 clear", d1_clear, 1'b0);
      end
      chk("stretch clear cycles", clr_high, 5);
      $display("step stretched clear: clear_o held while CLEAR publication stalled");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/cdc_clear_seq_ctrl.md
Name: cdc_clear_seq_ctrl

Overview:
Single-domain sequencer that walks one side of a CDC clear sequence through the clear_seq_phase_e phases (IDLE, ISOLATE, CLEAR, POST_CLEAR) from cdc_clear_sync_pkg. It drives the local isolate and clear controls. Every phase change is published over a valid/ready handshake to the downstream phase-transport stage, which carries it across the domain boundary. The sequencer does not advance past a phase until that phase's publication has been accepted.

Parameters:
CLEAR_CYCLES, 3, minimum number of cycles clear_o stays high in CLEAR; must be >= 1.
POST_CLEAR_CYCLES, 2, minimum number of cycles spent in POST_CLEAR; must be >= 1.

Ports:
clk_i  input  1  clock; single clock domain.
rst_i  input  1  reset; synchronous, active-high.
clear_req_i  input  1  request a clear sequence; may be a pulse or a level.
isolate_o  output  1  isolate local interface; registered.
isolate_ack_i  input  1  local interface is quiescent; level, sampled only in ISOLATE.
clear_o  output  1  clear local state; registered.
phase_o  output  2  current phase, of type cdc_clear_sync_pkg::clear_seq_phase_e; registered.
phase_valid_o  output  1  phase_o holds an unpublished phase.
phase_ready_i  input  1  downstream accepts phase_o.
busy_o  output  1  sequence in progress or publication outstanding.
clear_done_o  output  1  one-cycle pulse marking sequence completion.

Behaviour:
- Reset values (synchronous, rst_i high at a clock edge):
  - state=IDLE, phase_o=IDLE.
  - phase_valid_o, isolate_o, clear_o, clear_done_o, busy_o, pending and counter all 0.
  - Reset does not publish IDLE.
- Reset mid-sequence: on the next edge, return to the reset values. No clear_done_o pulse; any pending request is dropped.
- Handshake:
  - On every state entry, phase_o takes the new phase and phase_valid_o=1 in the same cycle.
  - phase_valid_o stays high, and phase_o stays stable, until a cycle where phase_valid_o && phase_ready_i.
  - In the following cycle phase_valid_o=0, unless that same edge also enters a new state; then it stays 1 with the new phase.
  - hs_done means the current phase's publication has been accepted, either in an earlier cycle or in the current cycle.
- State transitions (all taken at a clock edge):
  - IDLE -> ISOLATE when (clear_req_i || pending) && hs_done. Clears pending.
  - ISOLATE -> CLEAR when isolate_ack_i && hs_done.
  - CLEAR -> POST_CLEAR when cnt == CLEAR_CYCLES-1 && hs_done.
  - POST_CLEAR -> IDLE when cnt == POST_CLEAR_CYCLES-1 && hs_done. clear_done_o=1 in the first IDLE cycle only.
- Counter:
  - Reset to 0 on entry to CLEAR and to POST_CLEAR.
  - Increments each cycle in the state and saturates at the terminal value.
  - Width $clog2(max(CLEAR_CYCLES, POST_CLEAR_CYCLES)+1).
- Outputs per state:
  - isolate_o=1 in ISOLATE, CLEAR and POST_CLEAR.
  - clear_o=1 only in CLEAR, so clear_o is high for max(CLEAR_CYCLES, handshake-limited duration) cycles.
  - busy_o = (state != IDLE) || phase_valid_o.
- Pending request:
  - clear_req_i seen while busy, or in IDLE with publication outstanding, sets pending.
  - Multiple requests collapse into one.
  - A request seen in the same cycle the IDLE->ISOLATE transition is taken is consumed by that transition and does not set pending.
- isolate_ack_i may already be high on entry to ISOLATE. The minimum ISOLATE dwell is then 1 cycle.
- A level clear_req_i held high re-triggers back-to-back sequences. Each sequence still includes one IDLE cycle, and the IDLE publication must complete before the next sequence starts.

Test Plan:
- Basic sequence. Stimulus: phase_ready_i=1, isolate_ack_i=1, defaults (CLEAR_CYCLES=3, POST_CLEAR_CYCLES=2), clear_req_i pulse in cycle 0. Required response:
  - phase_o = ISOLATE in c1, CLEAR in c2-c4, POST_CLEAR in c5-c6, IDLE in c7.
  - clear_o high in c2-c4; isolate_o high in c1-c6.
  - clear_done_o high in c7 only; phase_valid_o high in c1, c2, c5 and c7.
- Backpressure. Stimulus: phase_ready_i=0 from c0 to c9, then 1, with a request in c0. Required response: phase_o=ISOLATE and phase_valid_o=1 held stable for c1-c10; CLEAR entered in c11.
- Isolation delay. Stimulus: isolate_ack_i rises in c6 (ready=1, request in c0). Required response: ISOLATE held for c1-c6; CLEAR in c7; clear_o high in c7-c9.
- Collapsed pending requests. Stimulus: requests in c0, c3 and c4 (ready=1, ack=1). Required response:
  - Exactly two sequences run; clear_done_o pulses in c7 and c14.
  - The second ISOLATE is in c8, after the IDLE publication in c7.
- Reset mid-sequence. Stimulus: rst_i high in c3, during CLEAR. Required response: in c4, phase_o=IDLE, clear_o=0, isolate_o=0, phase_valid_o=0 and busy_o=0; no clear_done_o pulse.
- Stretched CLEAR. Stimulus: CLEAR_CYCLES=1, with phase_ready_i low for the first 4 cycles of CLEAR. Required response: clear_o high for exactly 5 cycles; POST_CLEAR follows immediately after.
